// File: rtl/zzdl_rsp_tx_if.sv
// Handshake bundle between zzdl (push side), zzdl_rsp_tx and sj (valid/ready side).
// The zzdl__sj__par signal exists only when ZZDL_RSP_PARITY_EN is defined.
interface zzdl_rsp_tx_if #(
  parameter int DW = 16,
  parameter int TW = 4
);
  logic          zzdl__rsp__vld;
  logic [DW-1:0] zzdl__rsp__data;
  logic          zzdl__rsp__rdy;
  logic          zzdl__sj__vld;
  logic [DW-1:0] zzdl__sj__data;
  logic [TW-1:0] zzdl__sj__tag;
  logic          sj__zzdl__rdy;
`ifdef ZZDL_RSP_PARITY_EN
  logic          zzdl__sj__par;

  modport master (
    input  zzdl__rsp__vld, zzdl__rsp__data, sj__zzdl__rdy,
    output zzdl__rsp__rdy, zzdl__sj__vld, zzdl__sj__data, zzdl__sj__tag, zzdl__sj__par
  );
  modport slave (
    output zzdl__rsp__vld, zzdl__rsp__data, sj__zzdl__rdy,
    input  zzdl__rsp__rdy, zzdl__sj__vld, zzdl__sj__data, zzdl__sj__tag, zzdl__sj__par
  );
`else
  modport master (
    input  zzdl__rsp__vld, zzdl__rsp__data, sj__zzdl__rdy,
    output zzdl__rsp__rdy, zzdl__sj__vld, zzdl__sj__data, zzdl__sj__tag
  );
  modport slave (
    output zzdl__rsp__vld, zzdl__rsp__data, sj__zzdl__rdy,
    input  zzdl__rsp__rdy, zzdl__sj__vld, zzdl__sj__data, zzdl__sj__tag
  );
`endif
endinterface

// File: rtl/zzdl_rsp_tx.sv
// zzdl -> sj result return path: small FIFO, wrapping sequence tag, registered head.
// Optional per-entry even parity output when ZZDL_RSP_PARITY_EN is defined.
module zzdl_rsp_tx #(
  parameter int DW    = 16,
  parameter int DEPTH = 4,
  parameter int TW    = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  zzdl_rsp_tx_if.master            bus,
  output logic [$clog2(DEPTH):0]   rsp_cnt,
  output logic                     rsp_ovf,
  input  logic                     rsp_ovf_clr
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DW-1:0] mem_data_q [DEPTH];
  logic [TW-1:0] mem_tag_q  [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_nxt;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] tag_ctr_q, tag_ctr_d;
  logic          ovf_q, ovf_d;
  logic          vld_q, vld_d;
  logic          rdy_q, rdy_d;
  logic [DW-1:0] data_q, data_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          full, push, pop, drop;
`ifdef ZZDL_RSP_PARITY_EN
  logic          mem_par_q [DEPTH];
  logic          par_q, par_d, push_par;

  assign push_par = ^{tag_ctr_q, bus.zzdl__rsp__data};
`endif

  always_comb begin
    full      = (cnt_q == CW'(DEPTH));
    push      = bus.zzdl__rsp__vld && !full;
    drop      = bus.zzdl__rsp__vld && full;
    pop       = vld_q && bus.sj__zzdl__rdy;
    rd_nxt    = rd_ptr_q + AW'(1);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    tag_ctr_d = tag_ctr_q;
    ovf_d     = ovf_q;
    data_d    = data_q;
    tag_d     = tag_q;
`ifdef ZZDL_RSP_PARITY_EN
    par_d     = par_q;
`endif
    if (push) begin
      wr_ptr_d  = wr_ptr_q + AW'(1);
      tag_ctr_d = tag_ctr_q + TW'(1);
    end
    if (pop) rd_ptr_d = rd_nxt;
    cnt_d = cnt_q + CW'(push) - CW'(pop);
    // Set wins over clear when a push is dropped in the same cycle.
    if (drop)             ovf_d = 1'b1;
    else if (rsp_ovf_clr) ovf_d = 1'b0;
    // Head register follows the next stored entry, or the incoming one when the FIFO drains to it.
    if (pop && cnt_q > CW'(1)) begin
      data_d = mem_data_q[rd_nxt];
      tag_d  = mem_tag_q[rd_nxt];
`ifdef ZZDL_RSP_PARITY_EN
      par_d  = mem_par_q[rd_nxt];
`endif
    end else if (push && (cnt_q == CW'(0) || (pop && cnt_q == CW'(1)))) begin
      data_d = bus.zzdl__rsp__data;
      tag_d  = tag_ctr_q;
`ifdef ZZDL_RSP_PARITY_EN
      par_d  = push_par;
`endif
    end
    vld_d = (cnt_d != CW'(0));
    rdy_d = (cnt_d != CW'(DEPTH));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      cnt_q     <= '0;
      tag_ctr_q <= '0;
      ovf_q     <= 1'b0;
      vld_q     <= 1'b0;
      rdy_q     <= 1'b1;
      data_q    <= '0;
      tag_q     <= '0;
`ifdef ZZDL_RSP_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      cnt_q     <= cnt_d;
      tag_ctr_q <= tag_ctr_d;
      ovf_q     <= ovf_d;
      vld_q     <= vld_d;
      rdy_q     <= rdy_d;
      data_q    <= data_d;
      tag_q     <= tag_d;
`ifdef ZZDL_RSP_PARITY_EN
      par_q     <= par_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= bus.zzdl__rsp__data;
      mem_tag_q[wr_ptr_q]  <= tag_ctr_q;
`ifdef ZZDL_RSP_PARITY_EN
      mem_par_q[wr_ptr_q]  <= push_par;
`endif
    end
  end

  assign bus.zzdl__rsp__rdy = rdy_q;
  assign bus.zzdl__sj__vld  = vld_q;
  assign bus.zzdl__sj__data = data_q;
  assign bus.zzdl__sj__tag  = tag_q;
`ifdef ZZDL_RSP_PARITY_EN
  assign bus.zzdl__sj__par  = par_q;
`endif
  assign rsp_cnt = cnt_q;
  assign rsp_ovf = ovf_q;
endmodule

// File: doc/zzdl_rsp_tx.md
# zzdl_rsp_tx

Return-path transmitter carrying zzdl results back to sj, the opposite direction of the sj→zzdl request interface. Accepts results from zzdl on a push interface, buffers them in a small FIFO, tags each with a wrapping sequence number and presents them to sj on a valid/ready handshake. Instantiated once per sj/zzdl pair in the top level, beside the existing sj and zzdl instances.

## Interface

Parameters:
- DW, 16, result data width.
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TW, 4, sequence tag width.

Ports:
- clk  in  1  single clock.
- rst  in  1  reset; synchronous, active-high.
- zzdl__rsp__vld  in  1  result push strobe from zzdl.
- zzdl__rsp__data  in  DW  result data.
- zzdl__rsp__rdy  out  1  space available, i.e. !full; registered from count.
- zzdl__sj__vld  out  1  result valid toward sj.
- zzdl__sj__data  out  DW  result data toward sj.
- zzdl__sj__tag  out  TW  sequence tag of the presented result.
- sj__zzdl__rdy  in  1  sj accepts result.
- rsp_cnt  out  log2(DEPTH)+1  current occupancy.
- rsp_ovf  out  1  sticky overflow flag.
- rsp_ovf_clr  in  1  clears rsp_ovf.

## Operation

- Push happens when zzdl__rsp__vld=1 and the FIFO is not full. The entry stores {tag_ctr, data}, then tag_ctr increments modulo 2^TW and wraps from 2^TW−1 to 0.
- Push while full (count==DEPTH) is dropped even if a pop occurs in the same cycle. A dropped push sets rsp_ovf and does not advance tag_ctr.
- Pop happens when zzdl__sj__vld && sj__zzdl__rdy.
- Head entry drives zzdl__sj__data/tag from registers. vld=1 whenever count>0.
- While vld=1 and rdy=0, data and tag are held stable, and vld does not deassert.
- Push and pop in the same cycle with 0<count<DEPTH leave count unchanged. Both pointers advance.
- Pointers are log2(DEPTH) bits wide and wrap naturally. Full and empty are derived from rsp_cnt.
- rsp_ovf is set by a dropped push and cleared by rsp_ovf_clr. If both happen in the same cycle, set wins.
- Reset values: all pointers, tag_ctr and rsp_cnt are 0. zzdl__sj__vld=0, zzdl__sj__data=0, zzdl__sj__tag=0, rsp_ovf=0, zzdl__rsp__rdy=1.
- Reset mid-operation discards all buffered entries. The first post-reset push carries tag 0.

## Timing

- Latency: a push at edge N into an empty FIFO gives zzdl__sj__vld=1 with that entry from cycle N+1.
- Back-to-back: with rdy held at 1, there is one pop per cycle and throughput is 1 result/cycle.
- zzdl__rsp__rdy and rsp_cnt reflect state after the previous edge. There is no combinational path from sj__zzdl__rdy to any output.
- Push on the same cycle the last entry pops (count 1→1): vld stays 1 and the new entry is presented the next cycle.

## Configuration

- ZZDL_RSP_PARITY_EN defined:
  - Adds output zzdl__sj__par (1 bit), the even parity over {zzdl__sj__tag, zzdl__sj__data}. It is stored per entry at push.
  - It follows the same hold and reset (0) rules as data.
- ZZDL_RSP_PARITY_EN undefined: the port and its storage are absent. All other behaviour is identical.

## Test plan

- Reset then single push of 0x1234 with rdy=1 -> vld rises the next cycle with data=0x1234, tag=0; it pops, and vld=0 the following cycle.
- 4 pushes 0xA0..0xA3 with rdy=0 -> rsp_cnt=4, zzdl__rsp__rdy=0. A 5th push 0xA4 sets rsp_ovf=1 and is dropped. Raising rdy delivers 0xA0..0xA3 with tags 0..3. The next push carries tag 4.
- Stall: entry presented with rdy=0 for 5 cycles -> data, tag and vld unchanged each cycle; pop occurs on the cycle rdy=1.
- 20 back-to-back pushes with rdy=1 -> 20 in-order results with tags 0..15,0..3 (wrap), and rsp_cnt never exceeds 1.
- Reset asserted with 3 entries buffered -> the next cycle shows vld=0, rsp_cnt=0, rsp_ovf=0. A subsequent push gets tag 0.
- With ZZDL_RSP_PARITY_EN: data 0x0001, tag 0 -> par=1; data 0x0003, tag 0 -> par=0.
